// File: rtl/serdes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serdes_pkg
// Brief    : Shared serial-link definitions: FSM encoding and a width helper.
// Revision : 1.0 - initial release
// ============================================================================
package serdes_pkg;

    localparam int         c_STATE_W  = 1;
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    // $clog2 returns 0 for 1; a counter still needs at least one bit.
    function automatic int clog2_safe(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : bit_tick_gen
// Brief    : Bit-period divider; tick marks the last clk of each bit period.
// Revision : 1.0 - initial release
// ============================================================================
module bit_tick_gen
    import serdes_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    generate
        if (DIV == 1) begin : g_div1
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, clr, en};
            assign tick     = 1'b1;
        end else begin : g_divn
            localparam int                c_DCW = clog2_safe(DIV);
            localparam logic [c_DCW-1:0]  c_TOP = c_DCW'(DIV - 1);

            logic [c_DCW-1:0] r_div_cnt;

            assign tick = (r_div_cnt == c_TOP);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_div_cnt <= '0;
                end else if (clr) begin
                    r_div_cnt <= '0;
                end else if (en) begin
                    r_div_cnt <= tick ? '0 : r_div_cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Brief    : Valid/ready parallel-in, serial-out transmitter with frame flag.
// Revision : 1.0 - initial release
// ============================================================================
module piso_serializer
    import serdes_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sframe,
    output logic             busy,
    output logic             done
);

    localparam int               c_BCW  = clog2_safe(WIDTH);
    localparam logic [c_BCW-1:0] c_LAST = c_BCW'(WIDTH - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [WIDTH-1:0]     r_shreg;
    logic [WIDTH-1:0]     w_shreg_shifted;
    logic [c_BCW-1:0]     r_bit_cnt;
    logic                 r_done;
    logic                 w_tick;
    logic                 w_shifting;
    logic                 w_last;
    logic                 w_end_word;
    logic                 w_accept;

    assign w_shifting = (r_state == c_ST_SHIFT);
    assign w_last     = (r_bit_cnt == c_LAST);

    bit_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_accept),
        .en   (w_shifting),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ready opens in IDLE and in the closing clk of a word's last bit,
    // which is what lets consecutive words stream without a gap.
    always_comb begin
        w_state_nxt = r_state;
        din_ready   = 1'b0;
        w_end_word  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                din_ready = ~rst;
                if (din_valid && !rst) begin
                    w_state_nxt = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                if (w_tick && w_last) begin
                    w_end_word  = 1'b1;
                    din_ready   = ~rst;
                    w_state_nxt = din_valid ? c_ST_SHIFT : c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
        w_accept = din_valid & din_ready;
    end

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shreg_shifted = {r_shreg[WIDTH-2:0], 1'b0};
            assign sout            = r_shreg[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shreg_shifted = {1'b0, r_shreg[WIDTH-1:1]};
            assign sout            = r_shreg[0];
        end
    endgenerate

    // After the final shift the register is all zeros, so sout idles low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_end_word;
            if (w_accept) begin
                r_shreg   <= din;
                r_bit_cnt <= '0;
            end else if (w_shifting && w_tick) begin
                r_shreg   <= w_shreg_shifted;
                r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
            end
        end
    end

    assign sframe = r_state[0];
    assign busy   = r_state[0];
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Brief    : Directed bench; instance 0 is 8b/DIV1/MSB-first, 1 is 8b/DIV3/LSB-first.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din0 = '0;
    logic [7:0] din1 = '0;
    logic [1:0] valid = '0;
    logic [1:0] ready;
    logic [1:0] sout;
    logic [1:0] sframe;
    logic [1:0] busy;
    logic [1:0] done;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    piso_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1)) u_dut0 (
        .clk(clk), .rst(rst), .din(din0), .din_valid(valid[0]), .din_ready(ready[0]),
        .sout(sout[0]), .sframe(sframe[0]), .busy(busy[0]), .done(done[0])
    );

    piso_serializer #(.WIDTH(8), .DIV(3), .MSB_FIRST(0)) u_dut1 (
        .clk(clk), .rst(rst), .din(din1), .din_valid(valid[1]), .din_ready(ready[1]),
        .sout(sout[1]), .sframe(sframe[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A word occupies W*DIV consecutive output cycles; cycle p shows bit p/DIV.
    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int msb_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    logic [7:0] m_word [2] = '{8'h00, 8'h00};
    int         m_pos  [2] = '{0, 0};
    bit         m_act  [2] = '{1'b0, 1'b0};
    bit         m_done [2] = '{1'b0, 1'b0};
    bit         m_acc, m_last;

    function automatic bit m_ready(input int i);
        return !rst && (!m_act[i] || m_pos[i] == W * div_of(i) - 1);
    endfunction

    function automatic bit m_sout(input int i);
        int k;
        if (!m_act[i]) return 1'b0;
        k = m_pos[i] / div_of(i);
        return m_word[i][(msb_of(i) != 0) ? (W - 1 - k) : k];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i]  = 1'b0;
                m_pos[i]  = 0;
                m_done[i] = 1'b0;
                m_word[i] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_acc     = valid[i] && m_ready(i);
                m_last    = m_act[i] && (m_pos[i] == W * div_of(i) - 1);
                m_done[i] = m_last;
                if (m_acc) begin
                    m_word[i] = (i == 0) ? din0 : din1;
                    m_act[i]  = 1'b1;
                    m_pos[i]  = 0;
                end else if (m_last) begin
                    m_act[i] = 1'b0;
                end else if (m_act[i]) begin
                    m_pos[i] = m_pos[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("sout%0d", i),   {31'd0, sout[i]},   {31'd0, m_sout(i)});
            chk($sformatf("sframe%0d", i), {31'd0, sframe[i]}, {31'd0, m_act[i]});
            chk($sformatf("busy%0d", i),   {31'd0, busy[i]},   {31'd0, m_act[i]});
            chk($sformatf("done%0d", i),   {31'd0, done[i]},   {31'd0, m_done[i]});
            chk($sformatf("ready%0d", i),  {31'd0, ready[i]},  {31'd0, m_ready(i)});
        end
    end

    // ---------------- capture of the serial streams ----------------
    logic [31:0] cap0 = '0;
    int nfr0 = 0, ndone0 = 0, last_done0 = 0, prev_done0 = 0;
    int nfr1 = 0, ones1 = 0, ndone1 = 0, last_done1 = 0;
    int acc0 = 0, acc1 = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (sframe[0]) begin
                cap0 = {cap0[30:0], sout[0]};
                nfr0++;
            end
            if (done[0]) begin
                ndone0++;
                prev_done0 = last_done0;
                last_done0 = cyc;
            end
            if (sframe[1]) begin
                nfr1++;
                if (sout[1]) ones1++;
            end
            if (done[1]) begin
                ndone1++;
                last_done1 = cyc;
            end
        end
    end

    task automatic clear_caps();
        cap0 = '0; nfr0 = 0; ndone0 = 0; last_done0 = 0; prev_done0 = 0;
        nfr1 = 0; ones1 = 0; ndone1 = 0; last_done1 = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit got;
        int found_cyc;

        // 1: reset state, then a reset pulse while idle
        @(negedge clk);
        chk("rst_ready0", {31'd0, ready[0]}, 32'd0);
        idle(3);
        rst = 1'b0;
        #1;
        chk("post_rst_ready0", {31'd0, ready[0]}, 32'd1);
        chk("post_rst_sout0", {31'd0, sout[0]}, 32'd0);
        idle(3);
        rst = 1'b1;
        #1;
        chk("idle_rst_ready1", {31'd0, ready[1]}, 32'd0);
        idle(1);
        rst = 1'b0;
        idle(2);

        // 2: single word A5, MSB first, DIV=1
        clear_caps();
        din0 = 8'hA5; valid[0] = 1'b1;
        idle(1);
        valid[0] = 1'b0; acc0 = cyc;
        idle(12);
        chk("t2_word", cap0, 32'h0000_00A5);
        chk("t2_frame_len", nfr0, 8);
        chk("t2_done_cnt", ndone0, 1);
        chk("t2_done_lat", last_done0 - acc0, 8);

        // 3: back-to-back A5, 3C with valid held
        clear_caps();
        din0 = 8'hA5; valid[0] = 1'b1;
        idle(1);
        acc0 = cyc; din0 = 8'h3C;
        got = 1'b0; found_cyc = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (ready[0]) begin
                got = 1'b1;
                found_cyc = cyc;
            end
        end
        @(posedge clk); #1;
        valid[0] = 1'b0;
        chk("t3_second_accept", {31'd0, got}, 32'd1);
        chk("t3_accept_cycle", found_cyc - acc0, 7);
        idle(20);
        chk("t3_stream", cap0, 32'h0000_A53C);
        chk("t3_frame_len", nfr0, 16);
        chk("t3_done_cnt", ndone0, 2);
        chk("t3_done_gap", last_done0 - prev_done0, 8);

        // 4: DIV=3, LSB first, word 01
        clear_caps();
        din1 = 8'h01; valid[1] = 1'b1;
        idle(1);
        valid[1] = 1'b0; acc1 = cyc;
        idle(30);
        chk("t4_frame_len", nfr1, 24);
        chk("t4_ones", ones1, 3);
        chk("t4_done_cnt", ndone1, 1);
        chk("t4_done_lat", last_done1 - acc1, 24);

        // 5: valid held with changing din during SHIFT
        clear_caps();
        din0 = 8'h5A; valid[0] = 1'b1;
        idle(1);
        for (int j = 0; j < 6; j++) begin
            din0 = 8'($urandom);
            idle(1);
        end
        valid[0] = 1'b0;
        idle(10);
        chk("t5_word", cap0, 32'h0000_005A);
        chk("t5_frame_len", nfr0, 8);
        chk("t5_done_cnt", ndone0, 1);

        // 6: reset mid-word, then a clean word
        clear_caps();
        din0 = 8'hFF; valid[0] = 1'b1;
        idle(1);
        valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6_sout_drop", {31'd0, sout[0]}, 32'd0);
        chk("t6_sframe_drop", {31'd0, sframe[0]}, 32'd0);
        chk("t6_busy_drop", {31'd0, busy[0]}, 32'd0);
        idle(2);
        rst = 1'b0;
        idle(12);
        chk("t6_no_done", ndone0, 0);
        clear_caps();
        din0 = 8'h81; valid[0] = 1'b1;
        idle(1);
        valid[0] = 1'b0;
        idle(12);
        chk("t6_word", cap0, 32'h0000_0081);
        chk("t6_frame_len", nfr0, 8);
        chk("t6_done_cnt", ndone0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
